// File: rtl/register_unit_pkg.sv
// rtl/register_unit_pkg.sv - shared widths, index/word types and constants for the RV32I register file

package register_unit_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_word_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/register_unit_read_port.sv
// rtl/register_unit_read_port.sv - combinational read mux with x0 masking; forwarding under REGISTER_UNIT_WRITE_BYPASS_EN

module register_unit_read_port
    import register_unit_pkg::*;
#(
    parameter int XLEN  = register_unit_pkg::XLEN,
    parameter int NREGS = register_unit_pkg::NREGS
) (
    input  logic             rst_n,
    input  logic [XLEN-1:0]  regs [NREGS],
    input  reg_idx_t         idx,
    input  logic             wr_en,
    input  reg_idx_t         wr_idx,
    input  logic [XLEN-1:0]  wr_data,
    output logic [XLEN-1:0]  data
);

    logic [XLEN-1:0] stored;

    assign stored = (idx == ZERO_REG) ? '0 : regs[idx];

`ifdef REGISTER_UNIT_WRITE_BYPASS_EN
    logic hit;

    // Forward writeback data to decode in the same cycle; never for x0 or in reset.
    assign hit  = rst_n && wr_en && (wr_idx != ZERO_REG) && (wr_idx == idx);
    assign data = hit ? wr_data : stored;
`else
    logic unused_bypass_inputs;

    assign unused_bypass_inputs = ^{rst_n, wr_en, wr_idx, wr_data};
    assign data = stored;
`endif

endmodule

// File: rtl/register_unit.sv
// rtl/register_unit.sv - 32x32 register file, two async read ports, one sync write port (option: REGISTER_UNIT_WRITE_BYPASS_EN)

module register_unit
    import register_unit_pkg::*;
#(
    parameter int XLEN  = register_unit_pkg::XLEN,
    parameter int NREGS = register_unit_pkg::NREGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RUWr,
    input  reg_idx_t         rs1,
    input  reg_idx_t         rs2,
    input  reg_idx_t         rd,
    input  logic [XLEN-1:0]  RUDataWr,
    output logic [XLEN-1:0]  RUrs1,
    output logic [XLEN-1:0]  RUrs2
);

    logic [XLEN-1:0] regs [NREGS];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (RUWr && (rd != ZERO_REG)) begin
            regs[rd] <= RUDataWr;
        end
    end

    register_unit_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_read_rs1 (
        .rst_n   (rst_n),
        .regs    (regs),
        .idx     (rs1),
        .wr_en   (RUWr),
        .wr_idx  (rd),
        .wr_data (RUDataWr),
        .data    (RUrs1)
    );

    register_unit_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_read_rs2 (
        .rst_n   (rst_n),
        .regs    (regs),
        .idx     (rs2),
        .wr_en   (RUWr),
        .wr_idx  (rd),
        .wr_data (RUDataWr),
        .data    (RUrs2)
    );

endmodule

// File: tb/tb_register_unit.sv
// tb/tb_register_unit.sv - directed self-checking bench for register_unit

module tb_register_unit;

    logic        clk;
    logic        rst_n;
    logic        RUWr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] RUDataWr;
    logic [31:0] RUrs1;
    logic [31:0] RUrs2;

    int passed;
    int total;

    register_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RUWr     (RUWr),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .RUDataWr (RUDataWr),
        .RUrs1    (RUrs1),
        .RUrs2    (RUrs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        RUWr = 1'b1;
        rd = idx;
        RUDataWr = val;
        @(posedge clk);
        #1;
        RUWr = 1'b0;
    endtask

    initial begin
        passed = 0;
        total = 0;
        rst_n = 1'b0;
        RUWr = 1'b0;
        rs1 = '0;
        rs2 = '0;
        rd = '0;
        RUDataWr = '0;

        // Reset sweep while held in reset, with a write request that must be ignored.
        RUWr = 1'b1;
        rd = 5'd3;
        RUDataWr = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rs1[%0d]", i), RUrs1, 32'h0);
            check($sformatf("reset_rs2[%0d]", 31 - i), RUrs2, 32'h0);
        end
        @(negedge clk);
        RUWr = 1'b0;
        rst_n = 1'b1;
        rs1 = 5'd3;
        #1;
        check("reset_write_lost", RUrs1, 32'h0);

        // Write/readback sweep.
        for (int i = 1; i <= 15; i++) begin
            write_reg(5'(i), 32'hA5A5_0000 + 32'(i));
        end
        for (int j = 0; j <= 14; j += 2) begin
            rs1 = 5'(j);
            rs2 = 5'(j + 1);
            #1;
            check($sformatf("sweep_rs1[%0d]", j), RUrs1, (j == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(j));
            check($sformatf("sweep_rs2[%0d]", j + 1), RUrs2, 32'hA5A5_0000 + 32'(j + 1));
        end

        // x0 protection.
        write_reg(5'd0, 32'hDEAD_BEEF);
        rs1 = 5'd0;
        rs2 = 5'd0;
        #1;
        check("x0_rs1", RUrs1, 32'h0);
        check("x0_rs2", RUrs2, 32'h0);

        // Write-enable gating.
        write_reg(5'd5, 32'h1234_5678);
        @(negedge clk);
        RUWr = 1'b0;
        rd = 5'd5;
        RUDataWr = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        rs1 = 5'd5;
        rs2 = 5'd5;
        #1;
        check("gate_rs1", RUrs1, 32'h1234_5678);
        check("gate_rs2_same_idx", RUrs2, 32'h1234_5678);

        // Read-during-write.
        write_reg(5'd7, 32'h1);
        @(negedge clk);
        rs1 = 5'd7;
        rs2 = 5'd0;
        RUWr = 1'b1;
        rd = 5'd7;
        RUDataWr = 32'h2;
        #1;
`ifdef REGISTER_UNIT_WRITE_BYPASS_EN
        check("rdw_before_edge", RUrs1, 32'h2);
`else
        check("rdw_before_edge", RUrs1, 32'h1);
`endif
        check("rdw_x0_not_bypassed", RUrs2, 32'h0);
        @(posedge clk);
        #1;
        RUWr = 1'b0;
        #1;
        check("rdw_after_edge", RUrs1, 32'h2);

        // Async reset mid-run, with a write pending during the low pulse.
        write_reg(5'd9, 32'h0BAD_F00D);
        rs1 = 5'd9;
        rs2 = 5'd15;
        #1;
        check("pre_reset_rs1", RUrs1, 32'h0BAD_F00D);
        check("pre_reset_rs2", RUrs2, 32'hA5A5_000F);
        @(negedge clk);
        RUWr = 1'b1;
        rd = 5'd9;
        RUDataWr = 32'h7777_7777;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_rs1", RUrs1, 32'h0);
        check("async_reset_rs2", RUrs2, 32'h0);
        @(posedge clk);
        #1;
        check("reset_hold_rs1", RUrs1, 32'h0);
        @(negedge clk);
        RUWr = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_reset_write_lost", RUrs1, 32'h0);
        check("post_reset_rs2", RUrs2, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
